// File: rtl/double_matrix_normalise_pkg.sv
// Shared types for the matrix normalisation stage: IEEE-754 double alias,
// zero test and the job-sequencing FSM states.
package double_matrix_normalise_pkg;

  typedef logic [63:0] double;

  localparam double DOUBLE_ZERO = 64'h0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_NORM,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  // True for +0.0 and -0.0 (sign ignored).
  function automatic logic is_zero(input double d);
    return (d[62:52] == 11'd0) && (d[51:0] == 52'd0);
  endfunction

endpackage

// File: rtl/double_matrix_normalise_tag_pipe.sv
// Shift register of {valid, idx} tags that tracks results through a
// fixed-latency IP; only the valid bits are reset.
module fp_tag_pipe #(
  parameter int DEPTH = 10,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic [W-1:0] idx_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o,
  output logic         any_vld_o
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     idx_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    idx_q[0] <= idx_i;
    for (int i = 1; i < DEPTH; i++) idx_q[i] <= idx_q[i-1];
  end

  assign vld_o     = vld_q[DEPTH-1];
  assign idx_o     = idx_q[DEPTH-1];
  assign any_vld_o = |vld_q;

endmodule

// File: rtl/fp_div.sv
// Fixed-latency IEEE-754 double divider (a_i / b_i), round-to-nearest-even.
// Subnormal operands and underflowing results are flushed to signed zero.
module fp_div #(
  parameter int LATENCY = 10
) (
  input  logic        clk,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] q_o
);

  logic               sq;
  logic [10:0]        ea, eb;
  logic [51:0]        fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic               a_lt_b, rnd;
  logic [53:0]        num_m;
  logic [55:0]        quo;
  logic [52:0]        rem;
  logic [53:0]        mant_r;
  logic signed [12:0] exp_s;
  logic [63:0]        q_d;
  logic [63:0]        pipe_q [LATENCY];

  always_comb begin
    sq     = a_i[63] ^ b_i[63];
    ea     = a_i[62:52];
    eb     = b_i[62:52];
    fa     = a_i[51:0];
    fb     = b_i[51:0];
    a_zero = (ea == 11'd0);
    b_zero = (eb == 11'd0);
    a_inf  = (ea == 11'h7FF) && (fa == 52'd0);
    b_inf  = (eb == 11'h7FF) && (fb == 52'd0);
    a_nan  = (ea == 11'h7FF) && (fa != 52'd0);
    b_nan  = (eb == 11'h7FF) && (fb != 52'd0);
    // Pre-shift the dividend so the quotient always lands in [1,2).
    a_lt_b = (fa < fb);
    num_m  = a_lt_b ? {1'b1, fa, 1'b0} : {1'b0, 1'b1, fa};
    quo    = 56'({num_m, 55'd0} / {56'd0, 1'b1, fb});
    rem    = 53'({num_m, 55'd0} % {56'd0, 1'b1, fb});
    rnd    = quo[2] & ((|quo[1:0]) | (|rem) | quo[3]);
    mant_r = {1'b0, quo[55:3]} + {53'd0, rnd};
    exp_s  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd1023
           - $signed({12'd0, a_lt_b}) + $signed({12'd0, mant_r[53]});

    q_d = {sq, exp_s[10:0], mant_r[51:0]};
    if (exp_s >= 13'sd2047) q_d = {sq, 11'h7FF, 52'd0};
    else if (exp_s <= 13'sd0) q_d = {sq, 63'd0};
    if (a_zero || b_inf) q_d = {sq, 63'd0};
    if (a_inf || b_zero) q_d = {sq, 11'h7FF, 52'd0};
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) q_d = 64'h7FF8000000000000;
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= q_d;
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign q_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/double_matrix_normalise.sv
// Divides every element of a SIZE_A x SIZE_B double matrix by a norm, streaming
// the elements through a single pipelined fp_div and reassembling the result.
module double_matrix_normalise
  import double_matrix_normalise_pkg::*;
#(
  parameter int SIZE_A      = 8,
  parameter int SIZE_B      = 8,
  parameter int DIV_LATENCY = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SIZE_A*SIZE_B*64-1:0] mat,
  input  logic [63:0]                 norm,
  input  logic                        norm_valid,
  output logic [SIZE_A*SIZE_B*64-1:0] result,
  output logic                        valid,
  output logic                        busy,
  output logic                        div_zero
);

  localparam int N     = SIZE_A * SIZE_B;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 div_zero_q, div_zero_d;
  logic                 valid_q;
  logic [N*64-1:0]      res_out_q;
  logic [N*64-1:0]      res_pack;
  double                mat_q    [N];
  double                result_q [N];
  double                norm_q;
  double                div_q;
  logic                 tag_vld, tag_any;
  logic [IDX_W-1:0]     tag_idx;

  fp_div #(.LATENCY(DIV_LATENCY)) u_div (
    .clk (clk),
    .a_i (mat_q[idx_q]),
    .b_i (norm_q),
    .q_o (div_q)
  );

  fp_tag_pipe #(.DEPTH(DIV_LATENCY), .W(IDX_W)) u_tags (
    .clk       (clk),
    .rst       (rst),
    .vld_i     (state_q == ISSUE),
    .idx_i     (idx_q),
    .vld_o     (tag_vld),
    .idx_o     (tag_idx),
    .any_vld_o (tag_any)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = WAIT_NORM;
        div_zero_d = 1'b0;
      end
      WAIT_NORM: if (norm_valid) begin
        idx_d = '0;
        // Zero norm skips the divider; DRAIN falls straight through on the empty pipe.
        if (is_zero(norm)) begin
          state_d    = DRAIN;
          div_zero_d = 1'b1;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (idx_q == IDX_LAST) state_d = DRAIN;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      DRAIN:   if (!tag_any) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_pack = '0;
    for (int k = 0; k < N; k++) res_pack[k*64 +: 64] = result_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      div_zero_q <= 1'b0;
      valid_q    <= 1'b0;
      res_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      div_zero_q <= div_zero_d;
      valid_q    <= (state_q == DONE);
      if (state_q == DONE) res_out_q <= res_pack;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start)
      for (int k = 0; k < N; k++) mat_q[k] <= mat[k*64 +: 64];
    if (state_q == WAIT_NORM && norm_valid) begin
      norm_q <= norm;
      if (is_zero(norm))
        for (int k = 0; k < N; k++) result_q[k] <= DOUBLE_ZERO;
    end
    if (tag_vld) result_q[tag_idx] <= div_q;
  end

  assign result   = res_out_q;
  assign valid    = valid_q;
  assign busy     = (state_q != IDLE);
  assign div_zero = div_zero_q;

endmodule
